// File: rtl/imgproc_msg_pkg.sv
// Shared constants, FSM states and bounds decode for the image-processor message reader.
package imgproc_msg_pkg;

  localparam logic [2:0]  ADDR_STATUS = 3'd0;
  localparam logic [2:0]  ADDR_MSG    = 3'd1;
  localparam logic [2:0]  ADDR_ID     = 3'd2;
  localparam int          FLUSH_BIT   = 4;
  localparam logic [31:0] FLUSH_CMD   = 32'h1 << FLUSH_BIT;
  localparam logic [31:0] MSG_ID_RBB  = 32'h0052_4242;

  typedef enum logic [2:0] {
    POLL_WAIT, RD_STAT, RD_HDR, RD_BND, RD_PAD, LAT, PRESENT, FLUSH
  } state_t;

  typedef struct packed {
    logic [10:0] left;
    logic [10:0] right;
    logic        none;
  } bb_t;

  // x_min sits in [26:16], x_max in [10:0]; left > right flags an empty frame
  function automatic bb_t decode_bounds(input logic [31:0] w);
    bb_t r;
    r.left  = w[26:16];
    r.right = w[10:0];
    r.none  = (w[26:16] > w[10:0]);
    return r;
  endfunction

endpackage

// File: rtl/imgproc_msg_reader_poll_timer.sv
// Loadable down-counter pacing status polls; done while the count sits at zero.
module poll_timer #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset_n)          cnt <= '0;
    else if (load)         cnt <= load_val;
    else if (dec && !done) cnt <= cnt - 1'b1;
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/imgproc_msg_reader.sv
// Avalon-MM master draining RBB bounding-box messages from the image processor FIFO
// and presenting decoded bounds on a valid/ready stream.
module imgproc_msg_reader
  import imgproc_msg_pkg::*;
#(
  parameter int          POLL_CYCLES = 1024,
  parameter logic [31:0] MSG_ID      = MSG_ID_RBB,
  parameter int          MSG_WORDS   = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [2:0]  m_address,
  output logic        m_read,
  output logic        m_write,
  output logic [31:0] m_writedata,
  input  logic [31:0] m_readdata,
  input  logic        m_waitrequest,
  output logic        bb_valid,
  input  logic        bb_ready,
  output logic [10:0] bb_left,
  output logic [10:0] bb_right,
  output logic        bb_none,
  output logic [7:0]  sync_err_cnt
);

  localparam int TW = $clog2(POLL_CYCLES + 1);
  // POLL_WAIT is entered the cycle after the load, so it lasts exactly POLL_CYCLES cycles
  localparam logic [TW-1:0] RELOAD = TW'(POLL_CYCLES - 1);

  state_t     state, state_nx, ret_q, ret_nx;
  bb_t        bb_q;
  logic [7:0] err_q;
  logic [7:0] usedw;
  logic       tmr_load, tmr_dec, tmr_done;
  logic       hdr_bad, bnd_latch;

  assign usedw = m_readdata[15:8];

  poll_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .load_val (RELOAD),
    .dec      (tmr_dec),
    .done     (tmr_done)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= POLL_WAIT;
      ret_q <= POLL_WAIT;
      bb_q  <= '0;
      err_q <= '0;
    end else begin
      state <= state_nx;
      ret_q <= ret_nx;
      if (bnd_latch) bb_q <= decode_bounds(m_readdata);
      if (hdr_bad && err_q != 8'hFF) err_q <= err_q + 8'd1;
    end
  end

  always_comb begin
    state_nx    = state;
    ret_nx      = ret_q;
    m_read      = 1'b0;
    m_write     = 1'b0;
    m_address   = ADDR_STATUS;
    m_writedata = '0;
    bb_valid    = 1'b0;
    tmr_load    = 1'b0;
    tmr_dec     = 1'b0;
    hdr_bad     = 1'b0;
    bnd_latch   = 1'b0;
    case (state)
      POLL_WAIT: begin
        if (tmr_done) state_nx = RD_STAT;
        else          tmr_dec  = 1'b1;
      end
      RD_STAT, RD_HDR, RD_BND, RD_PAD: begin
        m_read    = 1'b1;
        m_address = (state == RD_STAT) ? ADDR_STATUS : ADDR_MSG;
        if (!m_waitrequest) begin
          ret_nx   = state;
          state_nx = LAT;
        end
      end
      // Data cycle; strobe is low here, which also gives the slave its idle gap
      LAT: begin
        case (ret_q)
          RD_STAT: begin
            if (int'(usedw) >= MSG_WORDS) state_nx = RD_HDR;
            else begin
              tmr_load = 1'b1;
              state_nx = POLL_WAIT;
            end
          end
          RD_HDR: begin
            if (m_readdata == MSG_ID) state_nx = RD_BND;
            else begin
              hdr_bad  = 1'b1;
              state_nx = FLUSH;
            end
          end
          RD_BND: begin
            bnd_latch = 1'b1;
            state_nx  = RD_PAD;
          end
          default: state_nx = PRESENT;
        endcase
      end
      PRESENT: begin
        bb_valid = 1'b1;
        if (bb_ready) state_nx = RD_STAT;
      end
      FLUSH: begin
        m_write     = 1'b1;
        m_writedata = FLUSH_CMD;
        if (!m_waitrequest) begin
          tmr_load = 1'b1;
          state_nx = POLL_WAIT;
        end
      end
      default: state_nx = POLL_WAIT;
    endcase
  end

  assign bb_left      = bb_q.left;
  assign bb_right     = bb_q.right;
  assign bb_none      = bb_q.none;
  assign sync_err_cnt = err_q;

endmodule

// File: tb/tb_imgproc_msg_reader.sv
// Directed bench for imgproc_msg_reader against a small Avalon slave FIFO model.
module tb_imgproc_msg_reader;

  localparam int N = 16;
  localparam logic [31:0] ID = 32'h0052_4242;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  m_address;
  logic        m_read, m_write;
  logic [31:0] m_writedata;
  logic [31:0] m_readdata = '0;
  logic        m_waitrequest;
  logic        bb_valid;
  logic        bb_ready = 1'b0;
  logic [10:0] bb_left, bb_right;
  logic        bb_none;
  logic [7:0]  sync_err_cnt;

  int total = 0;
  int bad = 0;

  imgproc_msg_reader #(.POLL_CYCLES(N)) dut (
    .clk(clk), .reset_n(reset_n), .m_address(m_address), .m_read(m_read),
    .m_write(m_write), .m_writedata(m_writedata), .m_readdata(m_readdata),
    .m_waitrequest(m_waitrequest), .bb_valid(bb_valid), .bb_ready(bb_ready),
    .bb_left(bb_left), .bb_right(bb_right), .bb_none(bb_none),
    .sync_err_cnt(sync_err_cnt)
  );

  always #5 clk = ~clk;

  // slave model state: written by the slave process only
  int          cyc = 0, a1_total = 0, stall_tot = 0, wr_cnt = 0;
  int          gap_viol = 0, rw_both = 0, hold_bad = 0, load_ack = 0;
  logic        last_acc = 1'b0, prev_stall = 1'b0;
  logic [2:0]  prev_addr = '0;
  logic [31:0] wr_last = '0;
  logic [31:0] fifo[$];
  int          rd_cyc[$];
  logic [2:0]  rd_addr[$];
  // stimulus controls: written by the initial block only
  int          load_req = 0, load_n = 0, a1_base = 0, stall_base = 0, stall_len = 0;
  logic [31:0] load_words[6];
  logic        bad_mode = 1'b0, stall_on = 1'b0;

  assign m_waitrequest = stall_on && m_read && (m_address == 3'd1) &&
                         (a1_total - a1_base == 1) && (stall_tot - stall_base < stall_len);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (load_req != load_ack) begin
      fifo.delete();
      for (int i = 0; i < load_n; i++) fifo.push_back(load_words[i]);
      load_ack <= load_req;
    end
    if (m_read && !m_waitrequest) begin
      rd_cyc.push_back(cyc);
      rd_addr.push_back(m_address);
      if (m_address == 3'd0)
        m_readdata <= bad_mode ? 32'h0000_0300 : {16'h0, 8'(fifo.size()), 8'h0};
      else if (m_address == 3'd1) begin
        a1_total <= a1_total + 1;
        if (bad_mode)            m_readdata <= 32'hDEAD_BEEF;
        else if (fifo.size() > 0) m_readdata <= fifo.pop_front();
        else                     m_readdata <= '0;
      end else m_readdata <= ID;
    end
    if (m_write && !m_waitrequest) begin
      wr_cnt  <= wr_cnt + 1;
      wr_last <= m_writedata;
      if (m_address == 3'd0 && m_writedata[4]) fifo.delete();
    end
    if (m_read && last_acc) gap_viol <= gap_viol + 1;
    if (m_read && m_write) rw_both <= rw_both + 1;
    if (prev_stall && (!m_read || m_address != prev_addr)) hold_bad <= hold_bad + 1;
    if (m_waitrequest) stall_tot <= stall_tot + 1;
    last_acc   <= m_read && !m_waitrequest;
    prev_stall <= m_waitrequest;
    prev_addr  <= m_address;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [31:0] w0, w1, w2, w3, w4, w5, input int n);
    load_words[0] = w0; load_words[1] = w1; load_words[2] = w2;
    load_words[3] = w3; load_words[4] = w4; load_words[5] = w5;
    load_n = n;
    load_req++;
  endtask

  // returns with reset_n just released; the next edge issues the first status read
  task automatic do_reset(input logic [31:0] w0, w1, w2, w3, w4, w5, input int n);
    reset_n  = 1'b0;
    bb_ready = 1'b0;
    load(w0, w1, w2, w3, w4, w5, n);
    tick(2);
    reset_n = 1'b1;
  endtask

  task automatic wait_valid(input int lim, output int n);
    n = 0;
    while (!bb_valid && n < lim) begin
      tick(1);
      n++;
    end
  endtask

  task automatic handshake;
    bb_ready = 1'b1;
    tick(1);
    bb_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    tick(3);
    total++;
    if ({m_read, m_write, bb_valid, bb_none} !== 4'b0) begin
      bad++; $display("FAIL reset_strobes got=%b want=0000", {m_read, m_write, bb_valid, bb_none});
    end
    total++;
    if ({m_address, m_writedata, bb_left, bb_right, sync_err_cnt} !== '0) begin
      bad++; $display("FAIL reset_values got addr=%0h wd=%0h l=%0d r=%0d err=%0d want all 0",
                      m_address, m_writedata, bb_left, bb_right, sync_err_cnt);
    end
    reset_n = 1'b1;
    tick(1);
    total++;
    if (m_read !== 1'b1 || m_address !== 3'd0) begin
      bad++; $display("FAIL first_status_read got rd=%b addr=%0d want rd=1 addr=0", m_read, m_address);
    end
  endtask

  task automatic test_single;
    int n, base;
    logic [11:0] addrs;
    logic spacing_ok;
    do_reset(ID, 32'h0064_01F4, 32'h0, 0, 0, 0, 3);
    base = rd_cyc.size();
    wait_valid(40, n);
    total++;
    if (n !== 9) begin bad++; $display("FAIL single_latency got=%0d want=9", n); end
    total++;
    if (bb_left !== 11'd100 || bb_right !== 11'd500 || bb_none !== 1'b0) begin
      bad++; $display("FAIL single_bounds got l=%0d r=%0d none=%b want l=100 r=500 none=0",
                      bb_left, bb_right, bb_none);
    end
    total++;
    if (rd_cyc.size() - base !== 4) begin
      bad++; $display("FAIL single_read_count got=%0d want=4", rd_cyc.size() - base);
    end else begin
      addrs = {rd_addr[base], rd_addr[base+1], rd_addr[base+2], rd_addr[base+3]};
      spacing_ok = (rd_cyc[base+1] - rd_cyc[base] == 2) && (rd_cyc[base+2] - rd_cyc[base+1] == 2) &&
                   (rd_cyc[base+3] - rd_cyc[base+2] == 2);
      total++;
      if (addrs !== 12'b000_001_001_001 || !spacing_ok) begin
        bad++; $display("FAIL single_read_seq got addrs=%b spaced=%b want 000001001001 spaced=1",
                        addrs, spacing_ok);
      end
    end
    handshake();
    total++;
    if (bb_valid !== 1'b0) begin bad++; $display("FAIL single_drop_valid got=%b want=0", bb_valid); end
  endtask

  task automatic test_none;
    int n;
    do_reset(ID, 32'hFA7F_F800, 32'h0, 0, 0, 0, 3);
    wait_valid(40, n);
    total++;
    if (bb_valid !== 1'b1 || bb_left !== 11'd639 || bb_right !== 11'd0 || bb_none !== 1'b1) begin
      bad++; $display("FAIL none_bounds got v=%b l=%0d r=%0d none=%b want v=1 l=639 r=0 none=1",
                      bb_valid, bb_left, bb_right, bb_none);
    end
    handshake();
  endtask

  task automatic test_bad_hdr;
    int n, k, w0;
    w0 = wr_cnt;
    do_reset(32'hDEAD_BEEF, 32'h1, 32'h2, 0, 0, 0, 3);
    n = 0;
    while (!m_write && n < 20) begin tick(1); n++; end
    total++;
    if (n !== 5 || m_address !== 3'd0 || m_writedata !== 32'h10 || m_read !== 1'b0) begin
      bad++; $display("FAIL flush_cmd got t=%0d addr=%0d wd=%0h rd=%b want t=5 addr=0 wd=10 rd=0",
                      n, m_address, m_writedata, m_read);
    end
    total++;
    if (sync_err_cnt !== 8'd1) begin bad++; $display("FAIL sync_err_one got=%0d want=1", sync_err_cnt); end
    k = 0;
    do begin tick(1); k++; end while (!m_read && k < 3 * N);
    total++;
    if (k !== N + 1) begin bad++; $display("FAIL flush_poll_gap got=%0d want=%0d", k, N + 1); end
    total++;
    if (wr_cnt - w0 !== 1 || wr_last !== 32'h10) begin
      bad++; $display("FAIL flush_write got n=%0d data=%0h want n=1 data=10", wr_cnt - w0, wr_last);
    end
  endtask

  task automatic test_low_usedw;
    int base, a0;
    do_reset(ID, 32'h0001_0002, 0, 0, 0, 0, 2);
    base = rd_cyc.size();
    a0 = a1_total;
    tick(N + 9);
    total++;
    if (rd_cyc.size() - base !== 2 || a1_total - a0 !== 0 || bb_valid !== 1'b0) begin
      bad++; $display("FAIL low_usedw_reads got n=%0d a1=%0d v=%b want n=2 a1=0 v=0",
                      rd_cyc.size() - base, a1_total - a0, bb_valid);
    end else begin
      total++;
      if (rd_addr[base] !== 3'd0 || rd_addr[base+1] !== 3'd0 || rd_cyc[base+1] - rd_cyc[base] !== N + 2) begin
        bad++; $display("FAIL low_usedw_gap got gap=%0d want=%0d", rd_cyc[base+1] - rd_cyc[base], N + 2);
      end
    end
  endtask

  task automatic test_back_to_back;
    int n, base, hold_err;
    do_reset(ID, 32'h00C8_012C, 32'h0, ID, 32'h0005_0005, 32'h0, 6);
    wait_valid(40, n);
    total++;
    if (bb_left !== 11'd200 || bb_right !== 11'd300 || bb_none !== 1'b0) begin
      bad++; $display("FAIL b2b_first got l=%0d r=%0d none=%b want l=200 r=300 none=0",
                      bb_left, bb_right, bb_none);
    end
    base = rd_cyc.size();
    hold_err = 0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (bb_valid !== 1'b1 || bb_left !== 11'd200 || bb_right !== 11'd300 || bb_none !== 1'b0 ||
          m_read !== 1'b0 || m_write !== 1'b0) hold_err++;
    end
    total++;
    if (hold_err !== 0 || rd_cyc.size() !== base) begin
      bad++; $display("FAIL b2b_hold got bad_cycles=%0d reads=%0d want 0 0", hold_err, rd_cyc.size() - base);
    end
    handshake();
    total++;
    if (bb_valid !== 1'b0 || m_read !== 1'b1 || m_address !== 3'd0) begin
      bad++; $display("FAIL b2b_restat got v=%b rd=%b addr=%0d want v=0 rd=1 addr=0", bb_valid, m_read, m_address);
    end
    wait_valid(40, n);
    total++;
    if (n !== 8) begin bad++; $display("FAIL b2b_second_latency got=%0d want=8", n); end
    total++;
    if (bb_left !== 11'd5 || bb_right !== 11'd5 || bb_none !== 1'b0) begin
      bad++; $display("FAIL b2b_second got l=%0d r=%0d none=%b want l=5 r=5 none=0", bb_left, bb_right, bb_none);
    end
    handshake();
  endtask

  task automatic test_waitreq_reset;
    int n;
    do_reset(ID, 32'h0123_0456, 32'h0, 0, 0, 0, 3);
    a1_base = a1_total; stall_base = stall_tot; stall_len = 5; stall_on = 1'b1;
    wait_valid(60, n);
    total++;
    if (n !== 14 || bb_left !== 11'h123 || bb_right !== 11'h456 || bb_none !== 1'b0) begin
      bad++; $display("FAIL stall_capture got t=%0d l=%0h r=%0h none=%b want t=14 l=123 r=456 none=0",
                      n, bb_left, bb_right, bb_none);
    end
    total++;
    if (stall_tot - stall_base !== 5 || hold_bad !== 0) begin
      bad++; $display("FAIL stall_hold got stalls=%0d unstable=%0d want 5 0", stall_tot - stall_base, hold_bad);
    end
    handshake();
    load(ID, 32'h0010_0020, 32'h0, 0, 0, 0, 3);
    a1_base = a1_total; stall_base = stall_tot; stall_len = 1000;
    n = 0;
    while (stall_tot - stall_base < 3 && n < 200) begin tick(1); n++; end
    total++;
    if (m_read !== 1'b1 || m_address !== 3'd1 || bb_left !== 11'h123) begin
      bad++; $display("FAIL parked_in_bnd got rd=%b addr=%0d l=%0h want rd=1 addr=1 l=123", m_read, m_address, bb_left);
    end
    reset_n = 1'b0;
    tick(1);
    total++;
    if ({m_read, m_write, bb_valid, bb_none, m_address, m_writedata, bb_left, bb_right, sync_err_cnt} !== '0) begin
      bad++; $display("FAIL midread_reset got rd=%b wr=%b v=%b addr=%0d l=%0d r=%0d want all 0",
                      m_read, m_write, bb_valid, m_address, bb_left, bb_right);
    end
    stall_on = 1'b0;
    reset_n  = 1'b1;
    tick(1);
    total++;
    if (m_read !== 1'b1 || m_address !== 3'd0) begin
      bad++; $display("FAIL poll_restart got rd=%b addr=%0d want rd=1 addr=0", m_read, m_address);
    end
  endtask

  task automatic test_sync_saturate;
    int n;
    do_reset(0, 0, 0, 0, 0, 0, 0);
    bad_mode = 1'b1;
    n = 0;
    while (sync_err_cnt !== 8'd255 && n < 256 * (N + 10)) begin tick(1); n++; end
    total++;
    if (sync_err_cnt !== 8'd255) begin bad++; $display("FAIL sync_err_reach got=%0d want=255", sync_err_cnt); end
    tick(3 * (N + 6));
    total++;
    if (sync_err_cnt !== 8'd255) begin bad++; $display("FAIL sync_err_saturate got=%0d want=255", sync_err_cnt); end
    bad_mode = 1'b0;
  endtask

  task automatic test_bus_rules;
    total++;
    if (gap_viol !== 0 || rw_both !== 0) begin
      bad++; $display("FAIL bus_rules got back_to_back=%0d rd_and_wr=%0d want 0 0", gap_viol, rw_both);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    tick(1);
    test_reset();
    test_single();
    test_none();
    test_bad_hdr();
    test_low_usedw();
    test_back_to_back();
    test_waitreq_reset();
    test_sync_saturate();
    test_bus_rules();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
